// File: rtl/sram_pkg.sv
// Shared constants and the read-return tag carried alongside each SRAM access.
package sram_pkg;

  localparam int SRAM_ADDR_W       = 18;
  localparam int SRAM_DATA_W       = 32;
  localparam int SRAM_READ_LATENCY = 4;
  localparam int SRAM_MASK_W       = 4;
  localparam int SRAM_ID_W         = 2;

  typedef struct packed {
    logic                 is_read;
    logic [SRAM_ID_W-1:0] id;
  } sram_tag_t;

  localparam int SRAM_TAG_W = $bits(sram_tag_t);

  function automatic logic [SRAM_ID_W-1:0] next_ptr(input logic [SRAM_ID_W-1:0] id,
                                                    input int n);
    return (int'(id) == n - 1) ? '0 : id + 2'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr (wrapping) wins.
module rr_arbiter
  import sram_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [SRAM_ID_W-1:0] ptr,
  output logic [NUM_REQ-1:0]   grant,
  output logic [SRAM_ID_W-1:0] grant_id,
  output logic                 grant_any
);

  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant_any && req[i] && (i == (int'(ptr) + off) % NUM_REQ)) begin
          grant[i]  = 1'b1;
          grant_id  = SRAM_ID_W'(i);
          grant_any = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin front end for the ZBT SRAM controller with in-order, tag-steered read return.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int ADDR_W       = SRAM_ADDR_W,
  parameter int DATA_W       = SRAM_DATA_W,
  parameter int READ_LATENCY = SRAM_READ_LATENCY
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ*4-1:0]      req_wmask,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      sram_addr_valid,
  input  logic                      sram_ready,
  output logic [ADDR_W-1:0]         sram_addr,
  output logic [DATA_W-1:0]         sram_wdata,
  output logic [3:0]                sram_wmask,
  input  logic [DATA_W-1:0]         sram_rdata,
  input  logic                      sram_rvalid,
  output logic                      rsp_err
);

  // Handshake: a request transfers on a cycle where req_valid[i] & req_ready[i];
  // until then the requester holds addr/wdata/wmask stable. req_ready is at most
  // one-hot and only asserted while the controller reports sram_ready.
  logic [SRAM_ID_W-1:0] rr_ptr_q;
  logic [SRAM_ID_W-1:0] sram_id_q;
  logic [SRAM_ID_W-1:0] grant_id;
  logic                 grant_any;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   arb_req;

  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;
  logic [3:0]           sel_wmask;

  sram_tag_t            tag_q [READ_LATENCY];
  sram_tag_t            push_tag;
  sram_tag_t            head;
  logic                 rsp_hit;
  logic [NUM_REQ-1:0]   rsp_valid_d;

  assign arb_req   = req_valid & {NUM_REQ{sram_ready & ~reset}};
  assign req_ready = grant;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req       (arb_req),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_id  (grant_id),
    .grant_any (grant_any)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wmask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
        sel_wmask = req_wmask[i*4 +: 4];
      end
    end
  end

  // Address and write data hold when idle; only valid and mask return to zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr_q        <= '0;
      sram_id_q       <= '0;
      sram_addr_valid <= 1'b0;
      sram_addr       <= '0;
      sram_wdata      <= '0;
      sram_wmask      <= '0;
    end else if (grant_any) begin
      rr_ptr_q        <= next_ptr(grant_id, NUM_REQ);
      sram_id_q       <= grant_id;
      sram_addr_valid <= 1'b1;
      sram_addr       <= sel_addr;
      sram_wdata      <= sel_wdata;
      sram_wmask      <= sel_wmask;
    end else begin
      sram_addr_valid <= 1'b0;
      sram_wmask      <= '0;
    end
  end

  // Idle cycles push an all-zero bubble so the head lines up with sram_rvalid.
  always_comb begin
    push_tag         = '0;
    push_tag.is_read = sram_addr_valid && (sram_wmask == 4'h0);
    push_tag.id      = sram_addr_valid ? sram_id_q : '0;
  end

  assign head = tag_q[READ_LATENCY-1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < READ_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= push_tag;
      for (int i = 1; i < READ_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign rsp_hit = sram_rvalid && head.is_read;

  always_comb begin
    rsp_valid_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid_d[i] = rsp_hit && (head.id == SRAM_ID_W'(i));
    end
  end

  // A return without a read tag, or a read tag without a return, is dropped and flagged.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= rsp_valid_d;
      if (rsp_hit) rsp_data <= sram_rdata;
      if (sram_rvalid != head.is_read) rsp_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural fixed-latency SRAM controller.
module tb_sram_arbiter;
  import sram_pkg::*;

  localparam int N  = 2;
  localparam int AW = 18;
  localparam int DW = 32;
  localparam int L  = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N*4-1:0]  req_wmask = '0;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            sram_addr_valid;
  logic            sram_ready = 1'b1;
  logic [AW-1:0]   sram_addr;
  logic [DW-1:0]   sram_wdata;
  logic [3:0]      sram_wmask;
  logic [DW-1:0]   sram_rdata;
  logic            sram_rvalid;
  logic            rsp_err;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  sram_arbiter #(
    .NUM_REQ      (N),
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .READ_LATENCY (L)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_wmask       (req_wmask),
    .rsp_valid       (rsp_valid),
    .rsp_data        (rsp_data),
    .sram_addr_valid (sram_addr_valid),
    .sram_ready      (sram_ready),
    .sram_addr       (sram_addr),
    .sram_wdata      (sram_wdata),
    .sram_wmask      (sram_wmask),
    .sram_rdata      (sram_rdata),
    .sram_rvalid     (sram_rvalid),
    .rsp_err         (rsp_err)
  );

  // Controller model: a sample seen in cycle k returns its read data in cycle k+L.
  typedef struct packed {
    logic          v;
    logic [DW-1:0] d;
  } ctl_t;

  ctl_t          ctl_q [L+1];
  logic [DW-1:0] mem [int];
  logic          m_rvalid = 1'b0;
  logic          spur_rvalid = 1'b0;
  logic [DW-1:0] m_rdata = '0;

  assign sram_rvalid = m_rvalid | spur_rvalid;
  assign sram_rdata  = m_rdata;

  always @(negedge clock) begin
    if (reset) begin
      for (int i = 0; i <= L; i++) ctl_q[i] = '0;
    end else begin
      for (int i = L; i > 0; i--) ctl_q[i] = ctl_q[i-1];
      ctl_q[0].v = sram_addr_valid && (sram_wmask == 4'h0);
      ctl_q[0].d = mem.exists(int'(sram_addr)) ? mem[int'(sram_addr)] : '0;
      if (sram_addr_valid && sram_wmask != 4'h0) mem[int'(sram_addr)] = sram_wdata;
    end
    m_rvalid = ctl_q[L].v;
    m_rdata  = ctl_q[L].d;
  end

  // Scoreboard: responses observed as {id, data}; id 3 marks a non-one-hot rsp_valid.
  logic [DW+1:0] got_q [$];
  logic [DW+1:0] exp_q [$];

  always @(negedge clock) begin
    if (!reset && rsp_valid != '0) begin
      if (rsp_valid == 2'b01)      got_q.push_back({2'd0, rsp_data});
      else if (rsp_valid == 2'b10) got_q.push_back({2'd1, rsp_data});
      else                         got_q.push_back({2'd3, rsp_data});
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [3:0] m);
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    req_wmask[i*4 +: 4]   = m;
  endtask

  task automatic do_reset();
    req_valid   = '0;
    spur_rvalid = 1'b0;
    sram_ready  = 1'b1;
    reset       = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    tick();
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b exp 00", req_ready); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b exp 00", rsp_valid); end
    checks++; if (rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data got %h exp 0", rsp_data); end
    checks++; if (sram_addr_valid !== 1'b0) begin errors++; $display("FAIL reset_addr_valid got %b exp 0", sram_addr_valid); end
    checks++; if (sram_addr !== '0) begin errors++; $display("FAIL reset_sram_addr got %h exp 0", sram_addr); end
    checks++; if (sram_wdata !== '0) begin errors++; $display("FAIL reset_sram_wdata got %h exp 0", sram_wdata); end
    checks++; if (sram_wmask !== 4'h0) begin errors++; $display("FAIL reset_sram_wmask got %h exp 0", sram_wmask); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b exp 0", rsp_err); end
    req_valid = '0;
  endtask

  task automatic test_single_read();
    int lat;
    logic [N-1:0]  rv;
    logic [DW-1:0] rd;
    lat = 0; rv = '0; rd = '0;
    do_reset();
    mem[32'h10] = 32'h1234_5678;
    tick();
    set_req(0, 18'h00010, '0, 4'h0);
    req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_grant got %b exp 01", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (sram_addr_valid !== 1'b1) begin errors++; $display("FAIL single_addr_valid got %b exp 1", sram_addr_valid); end
    checks++; if (sram_addr !== 18'h00010) begin errors++; $display("FAIL single_sram_addr got %h exp 00010", sram_addr); end
    checks++; if (sram_wmask !== 4'h0) begin errors++; $display("FAIL single_sram_wmask got %h exp 0", sram_wmask); end
    for (int k = 2; k <= 12; k++) begin
      tick();
      if (k == 2) begin
        checks++; if (sram_addr_valid !== 1'b0) begin errors++; $display("FAIL single_addr_valid_one_cycle got %b exp 0", sram_addr_valid); end
      end
      if (lat == 0 && rsp_valid != '0) begin
        lat = k; rv = rsp_valid; rd = rsp_data;
      end
    end
    checks++; if (lat != L + 2) begin errors++; $display("FAIL single_latency got %0d exp %0d", lat, L + 2); end
    checks++; if (rv !== 2'b01) begin errors++; $display("FAIL single_rsp_valid got %b exp 01", rv); end
    checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL single_rsp_data got %h exp 12345678", rd); end
  endtask

  task automatic test_contention();
    int n0, n1;
    logic [N-1:0] exp_g;
    n0 = 0; n1 = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      mem[32'h100 + i] = 32'hA000_0000 + i;
      mem[32'h200 + i] = 32'hB000_0000 + i;
    end
    for (int c = 0; c < 8; c++) begin
      tick();
      set_req(0, 18'(32'h100 + n0), '0, 4'h0);
      set_req(1, 18'(32'h200 + n1), '0, 4'h0);
      req_valid = 2'b11;
      #1;
      exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
      checks++; if (req_ready !== exp_g) begin errors++; $display("FAIL contention_grant_%0d got %b exp %b", c, req_ready, exp_g); end
      if (exp_g[0]) begin exp_q.push_back({2'd0, 32'hA000_0000 + n0}); n0++; end
      else          begin exp_q.push_back({2'd1, 32'hB000_0000 + n1}); n1++; end
    end
    tick();
    req_valid = '0;
    for (int w = 0; w < 20 && got_q.size() < 8; w++) tick();
    tick();
    checks++; if (got_q.size() != 8) begin errors++; $display("FAIL contention_rsp_count got %0d exp 8", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [DW+1:0] e, g;
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL contention_rsp got id %0d data %h exp id %0d data %h", g[DW+1:DW], g[DW-1:0], e[DW+1:DW], e[DW-1:0]); end
    end
  endtask

  task automatic test_write_read();
    do_reset();
    tick();
    set_req(1, 18'h3FFFF, 32'hDEAD_BEEF, 4'hF);
    req_valid = 2'b10;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL wr_grant got %b exp 10", req_ready); end
    tick();
    checks++; if (sram_addr_valid !== 1'b1 || sram_wmask !== 4'hF || sram_wdata !== 32'hDEAD_BEEF)
      begin errors++; $display("FAIL wr_issue got v %b m %h d %h exp v 1 m f d deadbeef", sram_addr_valid, sram_wmask, sram_wdata); end
    set_req(1, 18'h3FFFF, '0, 4'h0);
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rd_grant got %b exp 10", req_ready); end
    tick();
    req_valid = '0;
    for (int w = 0; w < 10; w++) tick();
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL wr_rd_rsp_count got %0d exp 1", got_q.size()); end
    if (got_q.size() > 0) begin
      checks++; if (got_q[0] !== {2'd1, 32'hDEAD_BEEF}) begin errors++; $display("FAIL wr_rd_rsp got id %0d data %h exp id 1 data deadbeef", got_q[0][DW+1:DW], got_q[0][DW-1:0]); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    mem[32'h55] = 32'h0BAD_F00D;
    sram_ready = 1'b0;
    set_req(0, 18'h00055, '0, 4'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      req_valid = 2'b01;
      #1;
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL stall_ready_%0d got %b exp 00", c, req_ready); end
      checks++; if (sram_addr_valid !== 1'b0) begin errors++; $display("FAIL stall_addr_valid_%0d got %b exp 0", c, sram_addr_valid); end
    end
    tick();
    sram_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL stall_release_grant got %b exp 01", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (sram_addr_valid !== 1'b1 || sram_addr !== 18'h00055) begin errors++; $display("FAIL stall_issue got v %b a %h exp v 1 a 00055", sram_addr_valid, sram_addr); end
    for (int w = 0; w < 8; w++) tick();
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL stall_rsp_count got %0d exp 1", got_q.size()); end
  endtask

  task automatic test_spurious();
    do_reset();
    for (int w = 0; w < 3; w++) tick();
    spur_rvalid = 1'b1;
    tick();
    spur_rvalid = 1'b0;
    checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL spur_err got %b exp 1", rsp_err); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL spur_rsp_valid got %b exp 00", rsp_valid); end
    for (int w = 0; w < 3; w++) tick();
    checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL spur_err_sticky got %b exp 1", rsp_err); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL spur_no_rsp got %0d exp 0", got_q.size()); end
  endtask

  task automatic test_reset_inflight();
    do_reset();
    for (int i = 0; i < 3; i++) mem[32'h20 + i] = 32'hC000_0000 + i;
    for (int i = 0; i < 3; i++) begin
      tick();
      set_req(0, 18'(32'h20 + i), '0, 4'h0);
      req_valid = 2'b01;
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL inflight_grant_%0d got %b exp 01", i, req_ready); end
    end
    tick();
    reset = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL inflight_reset_ready got %b exp 00", req_ready); end
    checks++; if (sram_addr_valid !== 1'b0) begin errors++; $display("FAIL inflight_reset_addr_valid got %b exp 0", sram_addr_valid); end
    checks++; if (sram_addr !== '0) begin errors++; $display("FAIL inflight_reset_sram_addr got %h exp 0", sram_addr); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL inflight_reset_rsp_valid got %b exp 00", rsp_valid); end
    tick();
    tick();
    reset = 1'b0;
    req_valid = '0;
    for (int w = 0; w < 12; w++) tick();
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL inflight_no_rsp got %0d exp 0", got_q.size()); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL inflight_err got %b exp 0", rsp_err); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_write_read();
    test_stall();
    test_spurious();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
